// File: rtl/slice_seq_ctrl.sv
// Slice sweep sequencer: walks nested outer/inner loops and emits 32-bit slice offsets into a 512-bit vector.
// Latency: first slice_valid one cycle after the start edge; one idle cycle between outer passes.
// Backpressure: slice_valid/slice_off hold until slice_ready; optional watchdog aborts long stalls.
//
// Build option: define SLICE_SEQ_WATCHDOG_EN to include the 7-bit stall watchdog.
//   Without it, timeout is tied to 0 and a stall can last indefinitely.
//
// Ports:
//   sysclk, reset       - rising-edge clock, asynchronous active-high reset
//   start               - sweep request, only looked at while idle
//   outer_lim           - last outer index N (outer loop runs i = 0..N)
//   inner_len           - maximum inner decrements per outer pass
//   slice_ready         - downstream extractor accepts the current offset
//   slice_valid         - slice_off is valid
//   slice_off           - bit offset k of slice zz[k+31:k]
//   slice_last          - qualifies the final slice of the sweep
//   busy                - high in every state except IDLE
//   done                - one-cycle pulse when the sweep finishes (or is aborted)
//   timeout             - sticky watchdog abort flag, cleared by the next start
//   sel_pulse           - high from reset until the first clock edge after reset drops

module slice_seq_ctrl #(
    parameter int OFF_W   = 9,
    parameter int MAX_OFF = 480,
    parameter int TIMEOUT = 100
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       outer_lim,
    input  logic [3:0]       inner_len,
    input  logic             slice_ready,
    output logic             slice_valid,
    output logic [OFF_W-1:0] slice_off,
    output logic             slice_last,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic             sel_pulse
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OUTER = 2'd1,
        INNER = 2'd2,
        DONE  = 2'd3
    } state_t;

    // acc + i never exceeds 120 + 15, so 9 bits hold the sum without wrap.
    localparam int SUM_W = 9;

    state_t           state;
    logic [3:0]       n_lim;
    logic [3:0]       l_lim;
    logic [3:0]       i;
    logic [3:0]       cnt;
    logic [7:0]       acc;
    logic [OFF_W-1:0] k;

    logic [SUM_W-1:0] acc_sum;
    logic [OFF_W-1:0] k_load;
    logic             pass_end;
    logic             last_load;
    logic             last_dec;
    logic             wd_fire;

    // The offset register doubles as the output so it is stable for the whole handshake.
    assign slice_off = k;

    // Running triangular sum acc + i, clamped to the highest legal slice start.
    assign acc_sum = SUM_W'(acc) + SUM_W'(i);

    always_comb begin
        k_load = OFF_W'(acc_sum);
        if (int'(acc_sum) > MAX_OFF) begin
            k_load = OFF_W'(MAX_OFF);
        end
    end

    // A pass ends either when the inner budget is spent or k has reached zero,
    // which also keeps k from ever decrementing below zero.
    assign pass_end = (cnt == l_lim) || (k == '0);

    // slice_last is registered, so it is computed from the values k/cnt are about to take:
    // on pass entry (cnt becomes 0, k becomes k_load) and on an inner decrement.
    assign last_load = (i == n_lim) && ((l_lim == 4'd0) || (k_load == '0));
    assign last_dec  = (i == n_lim) && (((cnt + 4'd1) == l_lim) || (k == OFF_W'(1)));

`ifdef SLICE_SEQ_WATCHDOG_EN
    logic [6:0] stall_tmr;

    // Fires on the stall cycle in which the timer already shows TIMEOUT-1,
    // i.e. after TIMEOUT consecutive cycles of valid without ready.
    assign wd_fire = (state == INNER) && !slice_ready && (stall_tmr == 7'(TIMEOUT - 1));

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            stall_tmr <= 7'd0;
            timeout   <= 1'b0;
        end else begin
            if ((state == INNER) && !slice_ready && !wd_fire) begin
                stall_tmr <= stall_tmr + 7'd1;
            end else begin
                stall_tmr <= 7'd0;
            end

            if (wd_fire) begin
                timeout <= 1'b1;
            end else if ((state == IDLE) && start) begin
                timeout <= 1'b0;
            end
        end
    end
`else
    assign wd_fire = 1'b0;
    assign timeout = 1'b0;
`endif

    // Marks the first cycle out of reset; set by reset, cleared by the first edge.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            sel_pulse <= 1'b1;
        end else begin
            sel_pulse <= 1'b0;
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            n_lim       <= 4'd0;
            l_lim       <= 4'd0;
            i           <= 4'd0;
            cnt         <= 4'd0;
            acc         <= 8'd0;
            k           <= '0;
            slice_valid <= 1'b0;
            slice_last  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (start) begin
                        n_lim <= outer_lim;
                        l_lim <= inner_len;
                        i     <= 4'd0;
                        acc   <= 8'd0;
                        cnt   <= 4'd0;
                        busy  <= 1'b1;
                        state <= OUTER;
                    end
                end

                OUTER: begin
                    acc         <= acc_sum[7:0];
                    k           <= k_load;
                    cnt         <= 4'd0;
                    slice_valid <= 1'b1;
                    slice_last  <= last_load;
                    state       <= INNER;
                end

                INNER: begin
                    if (wd_fire) begin
                        slice_valid <= 1'b0;
                        slice_last  <= 1'b0;
                        done        <= 1'b1;
                        state       <= DONE;
                    end else if (slice_ready) begin
                        if (pass_end) begin
                            slice_valid <= 1'b0;
                            slice_last  <= 1'b0;
                            if (i == n_lim) begin
                                done  <= 1'b1;
                                state <= DONE;
                            end else begin
                                i     <= i + 4'd1;
                                state <= OUTER;
                            end
                        end else begin
                            k          <= k - OFF_W'(1);
                            cnt        <= cnt + 4'd1;
                            slice_last <= last_dec;
                        end
                    end
                end

                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_slice_seq_ctrl.sv
// Testbench for slice_seq_ctrl: directed sweeps plus randomized sweeps with random stalls,
// checked against a loop-level reference model of the offset sequence.
// Define SLICE_SEQ_WATCHDOG_EN for both files to exercise the watchdog abort.

module tb_slice_seq_ctrl;

    localparam int OFF_W   = 9;
    localparam int MAX_OFF = 480;
    localparam int TIMEOUT = 4;
`ifdef SLICE_SEQ_WATCHDOG_EN
    localparam int STALL = 3;
`else
    localparam int STALL = 5;
`endif

    logic             sysclk;
    logic             reset;
    logic             start;
    logic [3:0]       outer_lim;
    logic [3:0]       inner_len;
    logic             slice_ready;
    logic             slice_valid;
    logic [OFF_W-1:0] slice_off;
    logic             slice_last;
    logic             busy;
    logic             done;
    logic             timeout;
    logic             sel_pulse;

    int n_assert = 0;
    int n_fail   = 0;

    // Expected sweep: one entry per slice.
    int exp_off[$];
    bit exp_last[$];
    bit exp_end[$];

    slice_seq_ctrl #(
        .OFF_W  (OFF_W),
        .MAX_OFF(MAX_OFF),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .sysclk     (sysclk),
        .reset      (reset),
        .start      (start),
        .outer_lim  (outer_lim),
        .inner_len  (inner_len),
        .slice_ready(slice_ready),
        .slice_valid(slice_valid),
        .slice_off  (slice_off),
        .slice_last (slice_last),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .sel_pulse  (sel_pulse)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: outputs are sampled on the falling edge, away from the active edge.
    task automatic tick();
        @(posedge sysclk);
        @(negedge sysclk);
    endtask

    // Reference: for i = 0..N, acc += i, k = min(acc, MAX_OFF), then emit k, k-1, ...
    // for up to L decrements, stopping early once k reaches 0.
    task automatic build(input int n, input int l);
        int acc;
        int kk;
        bit fin;
        exp_off.delete();
        exp_last.delete();
        exp_end.delete();
        acc = 0;
        for (int ii = 0; ii <= n; ii++) begin
            acc = acc + ii;
            kk  = (acc > MAX_OFF) ? MAX_OFF : acc;
            for (int c = 0; c <= 15; c++) begin
                fin = (c == l) || (kk == 0);
                exp_off.push_back(kk);
                exp_last.push_back((ii == n) && fin);
                exp_end.push_back(fin);
                if (fin) break;
                kk = kk - 1;
            end
        end
    endtask

    // Runs a full sweep. stall < 0 picks 0..2 stall cycles per slice at random;
    // poke asserts start during stalls, which must be ignored.
    task automatic run_sweep(input int n, input int l, input int stall, input bit poke);
        int gap;
        int ns;
        build(n, l);
        outer_lim   = 4'(n);
        inner_len   = 4'(l);
        slice_ready = 1'b0;
        start       = 1'b1;
        tick();
        start     = 1'b0;
        // Scramble the limits to show they were latched at start.
        outer_lim = 4'($urandom);
        inner_len = 4'($urandom);
        chk("busy_after_start", busy, 1);
        chk("timeout_cleared", timeout, 0);
        gap = 1;
        for (int s = 0; s < exp_off.size(); s++) begin
            repeat (gap) begin
                chk("valid_gap", slice_valid, 0);
                tick();
            end
            chk("valid_up", slice_valid, 1);
            chk("slice_off", slice_off, exp_off[s]);
            chk("slice_last", slice_last, exp_last[s]);
            ns = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
            for (int t = 0; t < ns; t++) begin
                slice_ready = 1'b0;
                if (poke) start = 1'b1;
                tick();
                start = 1'b0;
                chk("stall_valid", slice_valid, 1);
                chk("stall_off", slice_off, exp_off[s]);
                chk("stall_last", slice_last, exp_last[s]);
            end
            slice_ready = 1'b1;
            tick();
            slice_ready = 1'b0;
            gap = exp_end[s] ? 1 : 0;
        end
        chk("end_valid", slice_valid, 0);
        chk("end_done", done, 1);
        chk("end_busy", busy, 1);
        tick();
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_valid", slice_valid, 0);
        chk("idle_timeout", timeout, 0);
    endtask

    initial begin
        reset       = 1'b0;
        start       = 1'b0;
        outer_lim   = 4'd0;
        inner_len   = 4'd0;
        slice_ready = 1'b0;

        // Reset values, including sel_pulse holding until the first edge after release.
        #1 reset = 1'b1;
        #1;
        chk("rst_sel_pulse", sel_pulse, 1);
        chk("rst_valid", slice_valid, 0);
        chk("rst_off", slice_off, 0);
        chk("rst_last", slice_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_timeout", timeout, 0);
        repeat (2) @(negedge sysclk);
        chk("rst_hold_sel_pulse", sel_pulse, 1);
        reset = 1'b0;
        #1;
        chk("rel_sel_pulse_pre_edge", sel_pulse, 1);
        @(negedge sysclk);
        chk("rel_sel_pulse_post_edge", sel_pulse, 0);
        chk("rel_busy", busy, 0);
        chk("rel_valid", slice_valid, 0);
        chk("rel_done", done, 0);
        tick();
        chk("idle_no_start_busy", busy, 0);

        // Directed sweeps: nominal, single-pass, and stalled with start poked mid-sweep.
        run_sweep(2, 1, 0, 1'b0);
        run_sweep(0, 15, 0, 1'b0);
        run_sweep(2, 1, STALL, 1'b1);

`ifdef SLICE_SEQ_WATCHDOG_EN
        // Watchdog: ready held low, valid survives TIMEOUT stall cycles then drops.
        outer_lim = 4'd1;
        inner_len = 4'd2;
        start     = 1'b1;
        tick();
        start = 1'b0;
        chk("wd_outer_valid", slice_valid, 0);
        tick();
        for (int c = 0; c < TIMEOUT; c++) begin
            chk("wd_hold_valid", slice_valid, 1);
            tick();
        end
        chk("wd_abort_valid", slice_valid, 0);
        chk("wd_abort_timeout", timeout, 1);
        chk("wd_abort_done", done, 1);
        tick();
        chk("wd_after_done", done, 0);
        chk("wd_after_busy", busy, 0);
        chk("wd_sticky_timeout", timeout, 1);
`endif

        // Reset in the middle of INNER: immediate abort, no done pulse.
        outer_lim = 4'd3;
        inner_len = 4'd3;
        start     = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("mid_valid_before", slice_valid, 1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", slice_valid, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_sel_pulse", sel_pulse, 1);
        @(negedge sysclk);
        reset = 1'b0;
        tick();
        chk("mid_rel_busy", busy, 0);
        chk("mid_rel_done", done, 0);
        chk("mid_rel_valid", slice_valid, 0);
        chk("mid_rel_sel_pulse", sel_pulse, 0);

        // Randomized sweeps with random stalls.
        for (int r = 0; r < 8; r++) begin
            run_sweep(int'($urandom_range(0, 5)), int'($urandom_range(0, 6)), -1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/slice_seq_ctrl.md
SLICE_SEQ_CTRL -- requirements
Module: slice_seq_ctrl

Interface
REQ-001 Parameter OFF_W, default 9, slice-offset width; offsets address 32-bit slices of a 512-bit vector.
REQ-002 Parameter MAX_OFF, default 480, highest legal offset (offset+31 <= 511).
REQ-003 Parameter TIMEOUT, default 100, stall cycles before watchdog abort; range 1..127.
REQ-004 sysclk  in  1  sole clock, rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  sweep request; sampled only in IDLE.
REQ-007 outer_lim  in  4  last outer index N; outer loop runs i = 0..N.
REQ-008 inner_len  in  4  maximum inner decrements per outer pass.
REQ-009 slice_ready  in  1  downstream extractor accepts the current offset.
REQ-010 slice_valid  out  1  slice_off is valid.
REQ-011 slice_off  out  OFF_W  bit offset k of the requested slice zz[k+31:k].
REQ-012 slice_last  out  1  qualifies the final slice of the sweep.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  one-cycle pulse on sweep end.
REQ-015 timeout  out  1  sticky watchdog-abort flag.
REQ-016 sel_pulse  out  1  high from reset until the first sysclk edge after reset deasserts.

Function
REQ-017 The FSM SHALL have states IDLE, OUTER, INNER and DONE.
REQ-018 In IDLE, start=1 SHALL latch N=outer_lim and L=inner_len, clear i, acc, cnt and timeout, and go to OUTER.
REQ-019 OUTER lasts one cycle and SHALL set acc<=acc+i, k<=min(acc+i, MAX_OFF) and cnt<=0, then go to INNER.
REQ-020 In INNER, slice_valid=1 and slice_off=k; both SHALL hold stable until slice_ready=1.
REQ-021 On handshake with cnt==L or k==0: if i==N go to DONE, else i<=i+1 and go to OUTER.
REQ-022 On any other handshake, k<=k-1 and cnt<=cnt+1, staying in INNER.
REQ-023 slice_last SHALL be high during INNER when i==N and (cnt==L or k==0).
REQ-024 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-025 First slice_valid SHALL appear on the 2nd rising edge after start is sampled.
REQ-026 A handshake causing an outer step SHALL give a one-cycle slice_valid gap (the OUTER cycle).
REQ-027 start is ignored while busy=1.
REQ-028 outer_lim=0 SHALL run exactly one outer pass (i=0).
REQ-029 acc is 8 bits and non-wrapping (max 120); the offset clamp SHALL apply before loading k.
REQ-030 k SHALL never decrement below 0.

Reset
REQ-031 While reset=1, outputs SHALL be: state IDLE, slice_valid=0, slice_off=0, slice_last=0, busy=0, done=0, timeout=0, sel_pulse=1.
REQ-032 Reset mid-sweep SHALL abort immediately with no done pulse; the first edge after release returns to IDLE.
REQ-033 All internal counters (i, k, cnt, acc, stall timer) SHALL clear on reset.

Configuration
REQ-034 Macro SLICE_SEQ_WATCHDOG_EN, when defined, SHALL include a 7-bit stall timer.
REQ-035 The timer SHALL count cycles with slice_valid=1 and slice_ready=0, clearing on handshake or outside INNER.
REQ-036 When the timer reaches TIMEOUT-1 during a stall, the next edge SHALL drop slice_valid, set timeout=1 and enter DONE.
REQ-037 Without SLICE_SEQ_WATCHDOG_EN, timeout SHALL be constant 0, no timer exists and stalls are unbounded.

Verification
REQ-038 Release reset -> sel_pulse=1 until the first edge, then 0; all other outputs hold reset values.
REQ-039 outer_lim=2, inner_len=1, slice_ready=1 -> offsets 0,1,0,3,2; slice_last only on 2; one done pulse.
REQ-040 outer_lim=0, inner_len=15 -> single slice at offset 0 with slice_last=1; done two cycles later.
REQ-041 slice_ready low for 5 cycles mid-sweep -> slice_off stable; the sweep resumes unchanged.
REQ-042 With SLICE_SEQ_WATCHDOG_EN and TIMEOUT=4, slice_ready held low -> valid drops after 4 stall cycles; timeout=1, done=1.
REQ-043 Reset asserted during INNER -> busy=0 and slice_valid=0 immediately; start asserted mid-sweep is ignored.
